// File: rtl/tow_sequencer.sv
// tow_sequencer: round/game sequencer for the tug-of-war game.
// It walks the reset display, idle, wait, false start, go, score,
// game total and victory states. Its registered outputs select the LED
// pattern, enable the scoring datapath and flag false starts.
// Optional feature: define TOW_VICT_BLINK_EN to blink the victory pattern.
// Without it, the victory pattern is held steady.

module tow_sequencer #(
    parameter int RST_T   = 1000,
    parameter int WAIT_T  = 2000,
    parameter int SHOW_T  = 1500,
    parameter int BLINK_T = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start,
    input  logic       p1_press,
    input  logic       p2_press,
    input  logic       round_over,
    input  logic       game_over,
    output logic [3:0] led_control,
    output logic       round_active,
    output logic       false_start
);

    typedef enum logic [2:0] {
        S_RST,
        S_IDLE,
        S_WAIT,
        S_FAKE,
        S_GO,
        S_SCORE,
        S_TOTAL,
        S_VICT
    } state_t;

    localparam logic [15:0] RST_LIM  = 16'(RST_T - 1);
    localparam logic [15:0] WAIT_LIM = 16'(WAIT_T - 1);
    localparam logic [15:0] SHOW_LIM = 16'(SHOW_T - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_t      state;
    state_t      next_state;
    logic [15:0] tick_cnt;
    logic [15:0] tick_cnt_next;
    logic        game_flag;
    logic        game_flag_next;

    logic        rst_done;
    logic        wait_done;
    logic        show_done;
    logic        any_press;

    logic [3:0]  led_next;
    logic        round_active_next;
    logic        false_start_next;

    assign rst_done  = tick && (tick_cnt == RST_LIM);
    assign wait_done = tick && (tick_cnt == WAIT_LIM);
    assign show_done = tick && (tick_cnt == SHOW_LIM);
    assign any_press = p1_press || p2_press;

`ifdef TOW_VICT_BLINK_EN
    localparam logic [15:0] BLINK_LIM = 16'(BLINK_T - 1);

    logic [15:0] blink_cnt;
    logic [15:0] blink_cnt_next;
    logic        blink_phase;
    logic        blink_phase_next;

    // Victory blink timer: restarts lit on entry and toggles every BLINK_T ticks.
    always_comb begin
        blink_cnt_next   = blink_cnt;
        blink_phase_next = blink_phase;
        if (next_state == S_VICT && state != S_VICT) begin
            blink_cnt_next   = 16'd0;
            blink_phase_next = 1'b0;
        end else if (state == S_VICT && tick) begin
            if (blink_cnt == BLINK_LIM) begin
                blink_cnt_next   = 16'd0;
                blink_phase_next = ~blink_phase;
            end else begin
                blink_cnt_next = blink_cnt + 16'd1;
            end
        end
    end

    // Blink timer registers, cleared by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= 16'd0;
            blink_phase <= 1'b0;
        end else begin
            blink_cnt   <= blink_cnt_next;
            blink_phase <= blink_phase_next;
        end
    end
`endif

    // State register, shared tick counter and sampled game-over flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_RST;
            tick_cnt  <= 16'd0;
            game_flag <= 1'b0;
        end else begin
            state     <= next_state;
            tick_cnt  <= tick_cnt_next;
            game_flag <= game_flag_next;
        end
    end

    // Next-state logic. The counter clears on every state entry and saturates otherwise.
    always_comb begin
        next_state     = state;
        game_flag_next = game_flag;
        case (state)
            S_RST:   if (rst_done) next_state = S_IDLE;
            S_IDLE:  if (start) next_state = S_WAIT;
            S_WAIT: begin
                if (any_press)      next_state = S_FAKE;
                else if (wait_done) next_state = S_GO;
            end
            S_FAKE:  if (show_done) next_state = S_IDLE;
            S_GO: begin
                if (round_over) begin
                    next_state     = S_SCORE;
                    game_flag_next = game_over;
                end
            end
            S_SCORE: if (show_done) next_state = game_flag ? S_VICT : S_TOTAL;
            S_TOTAL: if (show_done) next_state = S_WAIT;
            S_VICT:  if (start) next_state = S_IDLE;
            default: next_state = S_RST;
        endcase

        if (next_state != state)
            tick_cnt_next = 16'd0;
        else if (tick && tick_cnt != CNT_MAX)
            tick_cnt_next = tick_cnt + 16'd1;
        else
            tick_cnt_next = tick_cnt;
    end

    // Output decode from the upcoming state, so the outputs update in step with the state.
    always_comb begin
        led_next          = 4'b0000;
        round_active_next = (next_state == S_GO);
        false_start_next  = (next_state == S_FAKE) && (state != S_FAKE);
        case (next_state)
            S_RST:   led_next = 4'b0001;
            S_IDLE:  led_next = 4'b0101;
            S_WAIT:  led_next = 4'b0010;
            S_FAKE:  led_next = 4'b0100;
            S_GO:    led_next = 4'b0110;
            S_SCORE: led_next = 4'b0011;
            S_TOTAL: led_next = 4'b0111;
`ifdef TOW_VICT_BLINK_EN
            S_VICT:  led_next = blink_phase_next ? 4'b0000 : 4'b1000;
`else
            S_VICT:  led_next = 4'b1000;
`endif
            default: led_next = 4'b0000;
        endcase
    end

    // Output registers; reset drives the reset-display pattern immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_control  <= 4'b0001;
            round_active <= 1'b0;
            false_start  <= 1'b0;
        end else begin
            led_control  <= led_next;
            round_active <= round_active_next;
            false_start  <= false_start_next;
        end
    end

endmodule

// File: tb/tb_tow_sequencer.sv
// tb_tow_sequencer: directed test of tow_sequencer with short timers
// (RST_T=2, WAIT_T=3, SHOW_T=2, BLINK_T=2) and tick held high every clk.
// The victory blink expectations follow TOW_VICT_BLINK_EN.

module tb_tow_sequencer;

    logic       clk;
    logic       reset_n;
    logic       tick;
    logic       start;
    logic       p1_press;
    logic       p2_press;
    logic       round_over;
    logic       game_over;
    logic [3:0] led_control;
    logic       round_active;
    logic       false_start;

    int errors;
    int checks;

    tow_sequencer #(
        .RST_T  (2),
        .WAIT_T (3),
        .SHOW_T (2),
        .BLINK_T(2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .start       (start),
        .p1_press    (p1_press),
        .p2_press    (p2_press),
        .round_over  (round_over),
        .game_over   (game_over),
        .led_control (led_control),
        .round_active(round_active),
        .false_start (false_start)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (led_control !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_led: got %b want 0001", led_control);
        end
        checks++;
        if (round_active !== 1'b0 || false_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got ra=%b fs=%b want 0 0", round_active, false_start);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (led_control !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL rst_hold: got %b want 0001", led_control);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (led_control !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL rst_to_idle: got %b want 0101", led_control);
        end
    endtask

    task automatic test_idle_ignore();
        p1_press   = 1'b1;
        p2_press   = 1'b1;
        round_over = 1'b1;
        game_over  = 1'b1;
        step();
        p1_press   = 1'b0;
        p2_press   = 1'b0;
        round_over = 1'b0;
        game_over  = 1'b0;
        step();
        step();
        step();
        checks++;
        if (led_control !== 4'b0101 || round_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_ignore: got led=%b ra=%b want 0101 0", led_control, round_active);
        end
    endtask

    task automatic test_false_start();
        logic saw_active;
        saw_active = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (led_control !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL start_to_wait: got %b want 0010", led_control);
        end
        step();
        p1_press = 1'b1;
        step();
        p1_press = 1'b0;
        saw_active = saw_active | round_active;
        checks++;
        if (led_control !== 4'b0100 || false_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fake_entry: got led=%b fs=%b want 0100 1", led_control, false_start);
        end
        step();
        saw_active = saw_active | round_active;
        checks++;
        if (led_control !== 4'b0100 || false_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fake_pulse_width: got led=%b fs=%b want 0100 0", led_control, false_start);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        saw_active = saw_active | round_active;
        checks++;
        if (led_control !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL fake_to_idle: got %b want 0101", led_control);
        end
        checks++;
        if (saw_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fake_round_active: got %b want 0", saw_active);
        end
    endtask

    task automatic test_round_total();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        checks++;
        if (led_control !== 4'b0010 || round_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_before_expiry: got led=%b ra=%b want 0010 0", led_control, round_active);
        end
        step();
        checks++;
        if (led_control !== 4'b0110 || round_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_to_go: got led=%b ra=%b want 0110 1", led_control, round_active);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (led_control !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL go_hold: got %b want 0110", led_control);
        end
        round_over = 1'b1;
        game_over  = 1'b0;
        step();
        round_over = 1'b0;
        checks++;
        if (led_control !== 4'b0011 || round_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL go_to_score: got led=%b ra=%b want 0011 0", led_control, round_active);
        end
        step();
        checks++;
        if (led_control !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL score_hold: got %b want 0011", led_control);
        end
        step();
        checks++;
        if (led_control !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL score_to_total: got %b want 0111", led_control);
        end
        step();
        step();
        checks++;
        if (led_control !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL total_to_wait: got %b want 0010", led_control);
        end
    endtask

    task automatic test_victory();
        step();
        step();
        step();
        checks++;
        if (led_control !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL second_go: got %b want 0110", led_control);
        end
        round_over = 1'b1;
        game_over  = 1'b1;
        step();
        round_over = 1'b0;
        game_over  = 1'b0;
        step();
        checks++;
        if (led_control !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL final_score: got %b want 0011", led_control);
        end
        step();
        checks++;
        if (led_control !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL score_to_vict: got %b want 1000", led_control);
        end
        step();
        checks++;
        if (led_control !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL vict_second: got %b want 1000", led_control);
        end
        step();
`ifdef TOW_VICT_BLINK_EN
        checks++;
        if (led_control !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL vict_blink_off: got %b want 0000", led_control);
        end
        step();
        checks++;
        if (led_control !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL vict_blink_off2: got %b want 0000", led_control);
        end
        step();
        checks++;
        if (led_control !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL vict_blink_on: got %b want 1000", led_control);
        end
`else
        step();
        step();
        checks++;
        if (led_control !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL vict_steady: got %b want 1000", led_control);
        end
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (led_control !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL vict_to_idle: got %b want 0101", led_control);
        end
    endtask

    task automatic test_coincident_press();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        p2_press = 1'b1;
        step();
        p2_press = 1'b0;
        checks++;
        if (led_control !== 4'b0100 || round_active !== 1'b0 || false_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL press_at_expiry: got led=%b ra=%b fs=%b want 0100 0 1",
                     led_control, round_active, false_start);
        end
        step();
        step();
        checks++;
        if (led_control !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL coincident_to_idle: got %b want 0101", led_control);
        end
    endtask

    task automatic test_reset_mid_round();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        checks++;
        if (round_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_go_active: got %b want 1", round_active);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (led_control !== 4'b0001 || round_active !== 1'b0 || false_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got led=%b ra=%b fs=%b want 0001 0 0",
                     led_control, round_active, false_start);
        end
        step();
        reset_n = 1'b1;
        step();
        step();
        checks++;
        if (led_control !== 4'b0101) begin
            errors++;
            $display("[TB] FAIL recover_idle: got %b want 0101", led_control);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        errors     = 0;
        checks     = 0;
        reset_n    = 1'b0;
        tick       = 1'b1;
        start      = 1'b0;
        p1_press   = 1'b0;
        p2_press   = 1'b0;
        round_over = 1'b0;
        game_over  = 1'b0;
        test_reset();
        test_idle_ignore();
        test_false_start();
        test_round_total();
        test_victory();
        test_coincident_press();
        test_reset_mid_round();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
